uart_rx_sv: RTL and testbench

UART_RX_SV -- requirements
Module: uart_rx_sv

---
 rtl/uart_rx_sv.sv | 149 ++++++++++++++
 tb/tb_uart_rx_sv.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sv.sv
// uart_rx_sv: 8N1 UART receiver. The line is synchronized, the start bit is
// qualified at mid-bit, and each bit is sampled near its centre. A good frame
// produces a one-cycle o_valid. A low stop bit produces a one-cycle
// o_frame_err and then waits for the line to return high.
module uart_rx_sv #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             half_hit, full_hit;

  assign half_hit = (baud_cnt_q == HALF_LAST);
  assign full_hit = (baud_cnt_q == BIT_LAST);

  // Two-flop synchronizer for the asynchronous line. It resets to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register, together with the counters, the shift register and the registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic. Any illegal encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (half_hit) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (full_hit && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (full_hit) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and strobe logic: baud counting, bit sampling, and frame result.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
      S_START: begin
        baud_cnt_d = half_hit ? '0 : baud_cnt_q + 1'b1;
      end
      S_DATA: begin
        if (full_hit) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          baud_cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        baud_cnt_d = '0;
      end
      default: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);

`ifndef SYNTHESIS
  // A frame is either good or bad, never both.
  assert property (@(posedge i_clk) !(o_valid && o_frame_err));
`endif

endmodule

// File: tb/tb_uart_rx_sv.sv
// Bench for uart_rx_sv. A serial driver plays the transmitter. Each frame
// pushes an expected event onto a queue: a good byte or a frame error, with
// its start cycle. A compare process checks every strobe against that queue,
// and checks the held o_data value on every cycle.
module tb_uart_rx_sv;

  localparam int CPB  = 25_000_000 / 115_200;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int n_ferr    = 0;
  int first_lat = -1;

  typedef struct {
    logic       good;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_data = 8'h00;

  uart_rx_sv dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: checks strobes against the model queue, and o_data against the last good byte.
  initial begin : cmp
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_data = 8'h00;
      end else begin
        if (o_valid || o_frame_err) begin
          if (o_frame_err) n_ferr++;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1'b0, int'({o_valid, o_frame_err}), 0);
          end else begin
            e   = exp_q.pop_front();
            lat = cyc - e.start;
            check("strobe_kind", {o_valid, o_frame_err} == (e.good ? 2'b10 : 2'b01),
                  int'({o_valid, o_frame_err}), e.good ? 2 : 1);
            check("latency", (lat >= LAT - 2) && (lat <= LAT + 2), lat, LAT);
            if (e.good) begin
              exp_data = e.data;
              if (first_lat < 0) first_lat = lat;
            end
          end
        end
        check("o_data_hold", o_data == exp_data, int'(o_data), int'(exp_data));
      end
    end
  end

  // Drive a line level for n clock cycles. Each call ends 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic good, input logic [7:0] b);
    exp_t e;
    e.good  = good;
    e.data  = b;
    e.start = cyc;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
    push_exp(stop, b);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, stop_len);
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size() == 0, exp_q.size(), 0);
  endtask

  // Watchdog: stop the run if the main sequence never reaches its summary.
  initial begin
    #(95_000 * 10);
    $display("FAIL watchdog: actual timeout required finish by cycle 95000");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         busy_cnt;
    logic [7:0] rb;
    int         gap;
    logic [7:0] part;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",  o_data == 8'h00, int'(o_data), 0);
    check("reset_valid", o_valid == 1'b0, int'(o_valid), 0);
    check("reset_ferr",  o_frame_err == 1'b0, int'(o_frame_err), 0);
    check("reset_busy",  o_busy == 1'b0, int'(o_busy), 0);
    rst = 1'b0;
    drive(1'b1, 20);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, CPB);
    drained("missing_0x00");
    send(8'hFF, 1'b1, CPB);
    drained("missing_0xFF");
    check("data_0xFF", o_data == 8'hFF, int'(o_data), 'hFF);
    check("busy_after_ff", o_busy == 1'b0, int'(o_busy), 0);
    check("latency_first", (first_lat >= 2061) && (first_lat <= 2065), first_lat, 2063);

    // Short low pulse that must be rejected as a glitch.
    drive(1'b1, 50);
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (o_busy) busy_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (o_busy) busy_cnt++;
    end
    check("glitch_busy_len", (busy_cnt > 0) && (busy_cnt <= 115), busy_cnt, 108);
    check("glitch_idle", o_busy == 1'b0, int'(o_busy), 0);
    drained("glitch_no_strobe");

    // 0xA5
    send(8'hA5, 1'b1, CPB);
    drained("missing_0xA5");
    check("data_0xA5", o_data == 8'hA5, int'(o_data), 'hA5);
    check("busy_after_a5", o_busy == 1'b0, int'(o_busy), 0);
    drive(1'b1, 30);

    // 0x3C with a low stop bit; the line stays low through a long break.
    send(8'h3C, 1'b0, 1000);
    drained("missing_ferr");
    check("ferr_count", n_ferr == 1, n_ferr, 1);
    check("data_kept_a5", o_data == 8'hA5, int'(o_data), 'hA5);
    check("busy_in_break", o_busy == 1'b1, int'(o_busy), 1);
    drive(1'b1, 200);
    check("break_released", o_busy == 1'b0, int'(o_busy), 0);
    check("ferr_count_after", n_ferr == 1, n_ferr, 1);
    send(8'h5A, 1'b1, CPB);
    drained("missing_0x5A");
    check("data_0x5A", o_data == 8'h5A, int'(o_data), 'h5A);
    drive(1'b1, 30);

    // 0x81 aborted by reset partway through data bit 4.
    part = 8'h81;
    push_exp(1'b1, part);
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(part[i], CPB);
    drive(part[4], 100);
    rst = 1'b1;
    drive(1'b1, 4);
    rst = 1'b0;
    drive(1'b1, 300);
    check("abort_data", o_data == 8'h00, int'(o_data), 0);
    check("abort_busy", o_busy == 1'b0, int'(o_busy), 0);
    drained("abort_no_strobe");
    send(8'h42, 1'b1, CPB);
    drained("missing_0x42");
    check("data_0x42", o_data == 8'h42, int'(o_data), 'h42);

    // Random bytes with random idle gaps, zero gap included.
    for (int k = 0; k < 20; k++) begin
      rb  = 8'($urandom);
      gap = (k % 4 == 0) ? 0 : int'($urandom_range(0, 300));
      send(rb, 1'b1, CPB);
      drained("missing_random");
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 10);
    check("final_idle", o_busy == 1'b0, int'(o_busy), 0);
    check("final_ferr_count", n_ferr == 1, n_ferr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
